// File: rtl/chess_pkg.sv
// Shared definitions for the move generator: piece codes, move-word geometry
// and the drain-stage state encoding.
package chess_pkg;

    localparam logic [2:0] EMPTY  = 3'd0;
    localparam logic [2:0] PAWN   = 3'd1;
    localparam logic [2:0] KNIGHT = 3'd2;
    localparam logic [2:0] BISHOP = 3'd3;
    localparam logic [2:0] ROOK   = 3'd4;
    localparam logic [2:0] QUEEN  = 3'd5;
    localparam logic [2:0] KING   = 3'd6;

    localparam logic WHITE = 1'b0;
    localparam logic BLACK = 1'b1;

    localparam int MOVW  = 19;
    localparam int NMOV  = 8;
    localparam int WORDW = 160;

    localparam logic [MOVW-1:0] PVOID = '0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_SCAN,
        ST_LOAD,
        ST_EMIT,
        ST_FIN
    } coll_state_t;

    // LSB of slot k; slot 0 sits just below the 8 reserved top bits.
    function automatic int slot_lo(input int k);
        return WORDW - 8 - MOVW * (k + 1);
    endfunction

endpackage

// File: rtl/move_collector_slot_picker.sv
// Lowest-set-bit finder over the per-word valid-slot mask.
module move_slot_picker #(
    parameter int NMOV = 8,
    parameter int IDXW = 3
) (
    input  logic [NMOV-1:0] i_mask,
    output logic            o_any,
    output logic [IDXW-1:0] o_idx
);

    always_comb begin
        o_any = |i_mask;
        o_idx = '0;
        for (int k = NMOV - 1; k >= 0; k--) begin
            if (i_mask[k]) begin
                o_idx = k[IDXW-1:0];
            end
        end
    end

endmodule

// File: rtl/move_collector.sv
// Drains the column move FIFOs A..H after all columns finish, unpacks the
// non-void move slots and streams them one per cycle over valid/ready.
module move_collector
    import chess_pkg::*;
#(
    parameter int NCOL  = 8,
    parameter int NMOV  = 8,
    parameter int MOVW  = 19,
    parameter int WORDW = 160,
    parameter int CNTW  = 10
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [NCOL-1:0]       col_done,
    input  logic [NCOL-1:0]       fifo_empty,
    input  logic [NCOL*WORDW-1:0] fifo_data,
    output logic [NCOL-1:0]       rden,
    output logic [MOVW-1:0]       mv_out,
    output logic [2:0]            mv_col,
    output logic                  mv_valid,
    input  logic                  mv_ready,
    output logic                  busy,
    output logic                  pass_done,
    output logic [CNTW-1:0]       mv_count
);

    coll_state_t      r_state;
    coll_state_t      w_next;
    logic [2:0]       r_ptr;
    logic [NMOV-1:0]  r_mask;
    logic [MOVW-1:0]  r_slot [NMOV];
    logic [NCOL-1:0]  r_rden;
    logic             r_pass_done;
    logic [CNTW-1:0]  r_cnt;

    logic [WORDW-1:0] w_word;
    logic [MOVW-1:0]  w_slot [NMOV];
    logic [NMOV-1:0]  w_ld_mask;
    logic [NMOV-1:0]  w_pick_mask;
    logic [NMOV-1:0]  w_mask_cleared;
    logic             w_any;
    logic [2:0]       w_idx;
    logic             w_hs;
    logic             w_last_col;

    always_comb begin
        w_word = '0;
        for (int i = 0; i < NCOL; i++) begin
            if (r_ptr == i[2:0]) begin
                w_word = fifo_data[i*WORDW +: WORDW];
            end
        end
    end

    always_comb begin
        for (int k = 0; k < NMOV; k++) begin
            w_slot[k]    = w_word[slot_lo(k) +: MOVW];
            w_ld_mask[k] = (w_slot[k] != PVOID);
        end
    end

    // LOAD only needs "any slot valid"; EMIT needs the index of the next slot.
    assign w_pick_mask = (r_state == ST_LOAD) ? w_ld_mask : r_mask;

    move_slot_picker #(
        .NMOV (NMOV),
        .IDXW (3)
    ) u_picker (
        .i_mask (w_pick_mask),
        .o_any  (w_any),
        .o_idx  (w_idx)
    );

    assign w_hs           = (r_state == ST_EMIT) && mv_ready;
    assign w_mask_cleared = r_mask & ~(NMOV'(1) << w_idx);
    assign w_last_col     = (r_ptr == 3'(NCOL - 1));

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (start) w_next = ST_WAIT;
            ST_WAIT: if (&col_done) w_next = ST_SCAN;
            ST_SCAN: begin
                if (!fifo_empty[r_ptr]) begin
                    w_next = ST_LOAD;
                end else if (w_last_col) begin
                    w_next = ST_FIN;
                end
            end
            ST_LOAD: w_next = w_any ? ST_EMIT : ST_SCAN;
            ST_EMIT: if (w_hs && (w_mask_cleared == '0)) w_next = ST_SCAN;
            ST_FIN:  w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_ptr       <= '0;
            r_mask      <= '0;
            r_rden      <= '0;
            r_pass_done <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_state     <= w_next;
            // LOAD is only entered from SCAN with the pointer unchanged.
            r_rden      <= (w_next == ST_LOAD) ? (NCOL'(1) << r_ptr) : '0;
            r_pass_done <= (r_state == ST_FIN);
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_ptr <= '0;
                        r_cnt <= '0;
                    end
                end
                ST_SCAN: begin
                    if (fifo_empty[r_ptr] && !w_last_col) begin
                        r_ptr <= r_ptr + 3'd1;
                    end
                end
                ST_LOAD: r_mask <= w_ld_mask;
                ST_EMIT: begin
                    if (w_hs) begin
                        r_mask <= w_mask_cleared;
                        if (r_cnt != '1) begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == ST_LOAD) begin
            for (int k = 0; k < NMOV; k++) begin
                r_slot[k] <= w_slot[k];
            end
        end
    end

    assign mv_valid  = (r_state == ST_EMIT);
    assign mv_out    = mv_valid ? r_slot[w_idx] : '0;
    assign mv_col    = mv_valid ? r_ptr : 3'd0;
    assign busy      = (r_state != ST_IDLE);
    assign rden      = r_rden;
    assign pass_done = r_pass_done;
    assign mv_count  = r_cnt;

endmodule

// File: tb/tb_move_collector.sv
// Randomised bench for move_collector: FIFO queues plus an expected-move list
// derived from the word layout, checked every cycle at the falling edge.
module tb_move_collector;

    localparam int NCOL  = 8;
    localparam int NMOV  = 8;
    localparam int MOVW  = 19;
    localparam int WORDW = 160;
    localparam int CNTW  = 10;
    localparam int TMO   = 3000;

    localparam logic [21:0] DLIT [3] = '{{3'd3, 19'h00101}, {3'd3, 19'h00202}, {3'd3, 19'h7FFFF}};

    logic                  clk = 1'b0;
    logic                  reset_n = 1'b0;
    logic                  start = 1'b0;
    logic [NCOL-1:0]       col_done = '0;
    logic [NCOL-1:0]       fifo_empty = '1;
    logic [NCOL*WORDW-1:0] fifo_data = '0;
    logic [NCOL-1:0]       rden;
    logic [MOVW-1:0]       mv_out;
    logic [2:0]            mv_col;
    logic                  mv_valid;
    logic                  mv_ready = 1'b0;
    logic                  busy;
    logic                  pass_done;
    logic [CNTW-1:0]       mv_count;

    always #5 clk = ~clk;

    move_collector #(
        .NCOL(NCOL), .NMOV(NMOV), .MOVW(MOVW), .WORDW(WORDW), .CNTW(CNTW)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .col_done(col_done),
        .fifo_empty(fifo_empty), .fifo_data(fifo_data), .rden(rden),
        .mv_out(mv_out), .mv_col(mv_col), .mv_valid(mv_valid), .mv_ready(mv_ready),
        .busy(busy), .pass_done(pass_done), .mv_count(mv_count)
    );

    logic [WORDW-1:0] fq [NCOL][$];
    logic [21:0]      exp_q [$];
    logic [21:0]      got_q [$];
    logic [MOVW-1:0]  sl [NMOV];
    logic [NCOL-1:0]  pend = '0;
    int               pops [NCOL];
    int               init_words [NCOL];
    int               n_total = 0;
    int               n_bad = 0;
    int               cyc = 0;
    int               t_start = 0;
    int               t_pd = -1;
    int               dones = 0;
    int               first_rden = -1;
    int               first_valid = -1;
    int               rmode = 0;
    logic             pv = 1'b0;
    logic             pr = 1'b0;
    logic [MOVW-1:0]  po = '0;
    logic [2:0]       pc = '0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Word layout: top 8 bits reserved (randomised), slot k at [151-19k -: 19].
    function automatic logic [WORDW-1:0] build_word();
        logic [WORDW-1:0] w;
        w = '0;
        w[WORDW-1 -: 8] = 8'($urandom);
        for (int k = 0; k < NMOV; k++) w[151 - 19*k -: 19] = sl[k];
        return w;
    endfunction

    task automatic drive_fifo();
        for (int c = 0; c < NCOL; c++) begin
            fifo_empty[c] = (fq[c].size() == 0);
            fifo_data[c*WORDW +: WORDW] = (fq[c].size() == 0) ? '0 : fq[c][0];
        end
    endtask

    // One cycle: apply last cycle's pop, check outputs, choose mv_ready.
    task automatic tick();
        @(negedge clk);
        cyc++;
        for (int c = 0; c < NCOL; c++) begin
            if (pend[c] && fq[c].size() > 0) void'(fq[c].pop_front());
        end
        drive_fifo();
        if (rden != '0) begin
            chk("rden_onehot", 32'($onehot(rden)), 32'd1);
            for (int c = 0; c < NCOL; c++) begin
                if (rden[c]) begin
                    chk("rden_nonempty", 32'(fq[c].size() > 0), 32'd1);
                    pops[c]++;
                    if (first_rden < 0) first_rden = cyc;
                end
            end
        end
        pend = rden;
        if (pv && !pr) begin
            chk("hold_valid", 32'(mv_valid), 32'd1);
            chk("hold_mv", 32'(mv_out), 32'(po));
            chk("hold_col", 32'(mv_col), 32'(pc));
        end
        case (rmode)
            0:       mv_ready = 1'b1;
            1:       mv_ready = ~mv_ready;
            default: mv_ready = ($urandom_range(0, 2) != 0);
        endcase
        if (mv_valid && first_valid < 0) first_valid = cyc;
        if (mv_valid && mv_ready) begin
            got_q.push_back({mv_col, mv_out});
            if (exp_q.size() == 0) begin
                n_total++;
                n_bad++;
                $display("FAIL extra_move: got=%0h want=none (cycle %0d)", {mv_col, mv_out}, cyc);
            end else begin
                chk("move", 32'({mv_col, mv_out}), 32'(exp_q[0]));
                void'(exp_q.pop_front());
            end
        end
        pv = mv_valid;
        pr = mv_ready;
        po = mv_out;
        pc = mv_col;
        if (pass_done) begin
            dones++;
            if (t_pd < 0) t_pd = cyc;
        end
    endtask

    task automatic run_pass(input int mode, input int abort_after, input int hold, output int t_done);
        logic [WORDW-1:0] w;
        logic [MOVW-1:0]  s;
        int               n_exp;
        exp_q.delete();
        got_q.delete();
        for (int c = 0; c < NCOL; c++) begin
            pops[c] = 0;
            init_words[c] = fq[c].size();
            for (int i = 0; i < fq[c].size(); i++) begin
                w = fq[c][i];
                for (int k = 0; k < NMOV; k++) begin
                    s = w[151 - 19*k -: 19];
                    if (s != '0) exp_q.push_back({3'(c), s});
                end
            end
        end
        n_exp = exp_q.size();
        rmode = mode;
        dones = 0;
        t_pd = -1;
        t_done = -1;
        first_rden = -1;
        first_valid = -1;
        pv = 1'b0;
        col_done = (hold > 0) ? 8'h7F : 8'hFF;
        start = 1'b1;
        t_start = cyc;
        tick();
        start = 1'b0;
        chk("busy_rise", 32'(busy), 32'd1);
        for (int i = 0; i < hold; i++) begin
            chk("wait_no_rden", 32'(rden), 32'd0);
            chk("wait_busy", 32'(busy), 32'd1);
            chk("wait_no_valid", 32'(mv_valid), 32'd0);
            tick();
        end
        col_done = 8'hFF;
        while (dones == 0 && (cyc - t_start) < TMO) begin
            if (abort_after > 0 && got_q.size() >= abort_after) break;
            tick();
        end
        if (abort_after > 0) begin
            chk("pre_abort_valid", 32'(mv_valid), 32'd1);
            #2 reset_n = 1'b0;
            #1;
            chk("abort_valid", 32'(mv_valid), 32'd0);
            chk("abort_busy", 32'(busy), 32'd0);
            chk("abort_rden", 32'(rden), 32'd0);
            tick();
            tick();
            pend = '0;
            reset_n = 1'b1;
            for (int i = 0; i < 12; i++) tick();
            chk("abort_no_done", 32'(dones), 32'd0);
            chk("abort_count", 32'(mv_count), 32'd0);
            for (int c = 0; c < NCOL; c++) fq[c].delete();
            drive_fifo();
            return;
        end
        if (dones == 0) begin
            n_total++;
            n_bad++;
            $display("FAIL pass_timeout: no pass_done within %0d cycles", TMO);
        end else begin
            t_done = t_pd - t_start;
        end
        for (int i = 0; i < 3; i++) tick();
        chk("done_once", 32'(dones), 32'd1);
        chk("all_moves", 32'(exp_q.size()), 32'd0);
        chk("count", 32'(mv_count), 32'((n_exp > 1023) ? 1023 : n_exp));
        chk("busy_after", 32'(busy), 32'd0);
        for (int c = 0; c < NCOL; c++) chk("pops", 32'(pops[c]), 32'(init_words[c]));
    endtask

    task automatic clear_slots();
        for (int k = 0; k < NMOV; k++) sl[k] = '0;
    endtask

    initial begin
        int td;
        int ncol0;
        reset_n = 1'b0;
        drive_fifo();
        tick();
        tick();
        chk("rst_rden", 32'(rden), 32'd0);
        chk("rst_valid", 32'(mv_valid), 32'd0);
        chk("rst_mv", 32'(mv_out), 32'd0);
        chk("rst_col", 32'(mv_col), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(pass_done), 32'd0);
        chk("rst_count", 32'(mv_count), 32'd0);
        reset_n = 1'b1;
        tick();

        // Column D: slots 0,2,7 populated.
        clear_slots();
        sl[0] = 19'h00101; sl[2] = 19'h00202; sl[7] = 19'h7FFFF;
        fq[3].push_back(build_word());
        run_pass(0, 0, 0, td);
        for (int i = 0; i < 3; i++) chk("d_mv", 32'((got_q.size() > i) ? got_q[i] : 22'h0), 32'(DLIT[i]));
        chk("d_pops", 32'(pops[3]), 32'd1);
        chk("d_count", 32'(mv_count), 32'd3);

        // Same word under toggling backpressure.
        fq[3].push_back(build_word());
        run_pass(1, 0, 0, td);
        for (int i = 0; i < 3; i++) chk("bp_mv", 32'((got_q.size() > i) ? got_q[i] : 22'h0), 32'(DLIT[i]));
        chk("bp_count", 32'(mv_count), 32'd3);

        // Column A: two full words; column H: one all-void word.
        for (int w = 0; w < 2; w++) begin
            for (int k = 0; k < NMOV; k++) sl[k] = MOVW'($urandom_range(1, 19'h7FFFF));
            fq[0].push_back(build_word());
        end
        clear_slots();
        fq[7].push_back(build_word());
        run_pass(0, 0, 0, td);
        chk("a_rden_lat", 32'(first_rden - t_start), 32'd3);
        chk("a_valid_lat", 32'(first_valid - t_start), 32'd4);
        chk("a_count", 32'(mv_count), 32'd16);
        chk("h_pops", 32'(pops[7]), 32'd1);
        ncol0 = 0;
        foreach (got_q[i]) if (got_q[i][21:19] == 3'd0) ncol0++;
        chk("a_col0_moves", 32'(ncol0), 32'd16);

        // All FIFOs empty.
        run_pass(0, 0, 0, td);
        chk("empty_latency", 32'(td), 32'd11);
        chk("empty_count", 32'(mv_count), 32'd0);

        // Column H not done yet: collector must idle in WAIT.
        for (int k = 0; k < NMOV; k++) sl[k] = MOVW'($urandom_range(0, 19'h7FFFF));
        sl[3] = 19'h12345;
        fq[0].push_back(build_word());
        run_pass(2, 0, 6, td);

        // Reset pulsed while emitting, then a clean pass.
        clear_slots();
        for (int k = 0; k < 5; k++) sl[k] = MOVW'($urandom_range(1, 19'h7FFFF));
        fq[1].push_back(build_word());
        run_pass(0, 2, 0, td);
        for (int k = 0; k < NMOV; k++) sl[k] = MOVW'($urandom_range(1, 19'h7FFFF));
        fq[5].push_back(build_word());
        run_pass(2, 0, 0, td);

        // Random contents and random backpressure.
        for (int p = 0; p < 12; p++) begin
            for (int c = 0; c < NCOL; c++) begin
                for (int w = 0; w < $urandom_range(0, 2); w++) begin
                    for (int k = 0; k < NMOV; k++)
                        sl[k] = ($urandom_range(0, 9) < 4) ? '0 : MOVW'($urandom_range(1, 19'h7FFFF));
                    if ($urandom_range(0, 5) == 0) clear_slots();
                    fq[c].push_back(build_word());
                end
            end
            run_pass($urandom_range(0, 2), 0, 0, td);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/move_collector.md
# move_collector

Downstream drain stage for the eight `columnUnit` instances of the move generator. After every column reports `done`, it visits each column's move FIFO in order A..H and pops every 160-bit word. It unpacks the eight 19-bit move slots in each word, discards void slots, and streams the remaining moves one per cycle over a valid/ready handshake to the move evaluator. It also reports a per-pass move count.

## Interface
Parameters:
- `NCOL`, 8, number of column units / FIFOs
- `NMOV`, 8, move slots per FIFO word
- `MOVW`, 19, move slot width
- `WORDW`, 160, FIFO word width
- `CNTW`, 10, move counter width

Ports:
- `clk`  in  1  system clock, rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle pulse; begins a drain pass; ignored while `busy`
- `col_done`  in  NCOL  `done` from each columnUnit; bit i = column i (0 = A)
- `fifo_empty`  in  NCOL  `fifoEmpty` from each column
- `fifo_data`  in  NCOL*WORDW  `fifoOut` of column i at bits [i*160 +: 160]; show-ahead (valid whenever not empty)
- `rden`  out  NCOL  one-hot pop strobe; at most one bit high per cycle
- `mv_out`  out  MOVW  current move
- `mv_col`  out  3  source column of `mv_out`
- `mv_valid`  out  1  `mv_out` valid
- `mv_ready`  in  1  consumer accepts when `mv_valid && mv_ready`
- `busy`  out  1  high from the cycle after an accepted `start` until `pass_done`
- `pass_done`  out  1  one-cycle pulse at end of pass
- `mv_count`  out  CNTW  moves accepted in current/last pass

## Operation
- Word layout: bits [159:152] reserved and ignored; slot k (k=0..7) = bits [151-19k -: 19]. Slot 0 = `fifoMv1` and is emitted first.
- A slot equal to PVOID (all zero) is void and is never emitted.
- States: IDLE, WAIT, SCAN, LOAD, EMIT, FIN.
- IDLE: outputs quiet. On `start`: clear `mv_count` and `ptr`, go to WAIT.
- WAIT: stay until `col_done` is all ones, then go to SCAN.
- SCAN: if `fifo_empty[ptr]`, increment `ptr`. When `ptr` == 7 and column 7 is empty, go to FIN; otherwise stay in SCAN. If not empty, go to LOAD.
- LOAD: drive `rden[ptr]`=1 for this cycle only. Capture `fifo_data` slot for `ptr` into `word_q`. Set `mask_q[k]` = (slot k != 0). Go to EMIT if `mask_q` is nonzero, else go back to SCAN with the same `ptr`.
- EMIT: `mv_out` = lowest-index set slot of `mask_q`; `mv_valid`=1; `mv_col`=`ptr`.
  - On handshake: clear that mask bit and increment `mv_count` (saturating at 2^CNTW-1).
  - When the last bit clears, return to SCAN with the same `ptr`, so the same column is re-checked for further words.
  - Without a handshake, `mv_out`/`mv_col` hold stable.
- FIN: pulse `pass_done`, go to IDLE. `mv_count` holds until the next `start`.
- A column that becomes non-empty after `ptr` has passed it is not revisited in this pass.
- `start` outside IDLE is ignored.

## Timing
- Reset values: all `rden`=0, `mv_valid`=0, `mv_out`=0, `mv_col`=0, `busy`=0, `pass_done`=0, `mv_count`=0, state IDLE.
- Asserting `reset_n` low mid-pass aborts immediately. The popped word is lost; no `pass_done` is issued.
- `start` sampled at edge 0 with all done and column A non-empty:
  - WAIT at edge 1
  - SCAN at edge 2
  - LOAD (`rden[0]` high) in cycle 3
  - first `mv_valid` in cycle 4
- Each empty column costs one SCAN cycle. An all-void word costs one LOAD and one SCAN cycle.
- Throughput: one move per cycle while `mv_ready`=1 within a word. Word-to-word overhead is 2 cycles (SCAN+LOAD).
- `rden` is registered. A FIFO is never popped while its `fifo_empty` is high.
- All-empty pass: `start` at edge 0 → `pass_done` in cycle 11 (WAIT 1 + 8 SCAN cycles + FIN).

## Structure
- Shared package `chess_pkg`:
  - piece/colour constants (EMPTY..KING, WHITE/BLACK)
  - `PVOID`
  - `MOVW`, `NMOV`, `WORDW`
  - slot offset function
  - collector state enum
- One sub-module, `move_slot_picker`: combinational 8-bit mask → {any, 3-bit lowest-set index}. Used in LOAD (any) and EMIT (index).
- Mux of `fifo_data` by `ptr` and slot extraction stay in the top.

## Test plan
- Reset: `reset_n`=0 → all outputs 0. `start` with `col_done`=8'h7F → stays in WAIT, no `rden`. Set bit 7 → proceeds.
- Column D holds one word with slots 0,2,7 = 19'h00101, 19'h00202, 19'h7FFFF, others 0. Other columns empty. `mv_ready`=1 → exactly 3 moves in that order, `mv_col`=3, one `rden[3]` pulse, `mv_count`=3, `pass_done` once.
- Backpressure: `mv_ready` toggling 0/1 each cycle → each move held stable while unaccepted. No duplicate or lost moves.
- Column A holds two words of 8 valid moves each; column H holds one all-zero word → 16 moves from column 0. `rden[7]` pulses once, nothing is emitted for H, `mv_count`=16.
- All FIFOs empty → `pass_done` exactly 11 cycles after `start`, `mv_count`=0.
- `reset_n` pulsed low during EMIT → `mv_valid` drops asynchronously, no `pass_done`. A new `start` completes a clean pass.
